// File: rtl/vram_frame_reader_pkg.sv
// Shared frame-store packing for the camera writer and the display reader.
// Word address layout: {row[8:0], field, xword[8:0]}, two 18-bit pixels per 36-bit word.
package vram_pkg;

  localparam int ROW_W     = 9;
  localparam int FIELD_W   = 1;
  localparam int XWORD_W   = 9;
  localparam int PIX_W     = 18;
  localparam int WORD_W    = 36;
  localparam int ADDR_W    = 19;
  localparam int IMG_W_DEF = 720;
  localparam int IMG_H_DEF = 480;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } rd_state_e;

  // y[0] is the field bit, so interlaced lines land in separate half-banks.
  function automatic logic [ADDR_W-1:0] vram_pack_addr(input logic [XWORD_W-1:0] xword,
                                                       input logic [ROW_W:0]     y);
    return {y[ROW_W:FIELD_W], y[0], xword};
  endfunction

endpackage

// File: rtl/vram_frame_reader_sync_delay.sv
// N-deep, W-wide shift register with async active-low reset; aligns side signals
// with the ZBT read pipeline.
module vram_sync_delay #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/vram_frame_reader.sv
// Display-side frame store reader: beam position -> ZBT address -> pixel, syncs re-timed by L.
// Build option VRAM_TEST_PATTERN_EN adds an 8-bar test pattern selected by test_mode.
module vram_frame_reader
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int X_OFFSET     = 0,
  parameter int Y_OFFSET     = 0,
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              frame_in,
  input  logic              test_mode,
  input  logic [WORD_W-1:0] vram_read_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_bank,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output rd_state_e         fsm_state
);

  localparam int L = READ_LATENCY + 2;

  logic [10:0] x, y;
  logic        in_window, frame_start, frame_meta, frame_sync, run_win;

  assign x           = hcount - 11'(X_OFFSET);
  assign y           = {1'b0, vcount} - 11'(Y_OFFSET);
  assign in_window   = (x < 11'(IMG_W)) && (y < 11'(IMG_H));
  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
  assign run_win     = in_window && (fsm_state == RUN);

  // Bank swaps only at frame start so a frame is never read from two banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state  <= WAIT_FRAME;
      vram_addr  <= '0;
      vram_bank  <= 1'b0;
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      frame_meta <= frame_in;
      frame_sync <= frame_meta;
      if (frame_start) begin
        vram_bank <= ~frame_sync;
        fsm_state <= RUN;
      end
      if (in_window) vram_addr <= vram_pack_addr(x[XWORD_W:1], y[ROW_W:0]);
    end
  end

  vram_sync_delay #(.N(L), .W(3)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hsync_in, vsync_in, blank_in}),
    .q     ({hsync_out, vsync_out, blank_out})
  );

  // Control rides L-1 stages so it meets the read data at the pixel register.
`ifdef VRAM_TEST_PATTERN_EN
  localparam int CTL_W = 6;
  logic [CTL_W-1:0] ctl_in, ctl_q;
  assign ctl_in = {run_win, x[0], test_mode, x[9:7]};
`else
  localparam int CTL_W = 2;
  logic [CTL_W-1:0] ctl_in, ctl_q;
  logic             unused_test_mode;
  assign ctl_in           = {run_win, x[0]};
  assign unused_test_mode = test_mode;
`endif

  vram_sync_delay #(.N(L-1), .W(CTL_W)) u_ctl_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctl_in),
    .q     (ctl_q)
  );

  // pixel_valid qualifies pixel on every cycle; there is no backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= ctl_q[CTL_W-1];
      if (!ctl_q[CTL_W-1]) pixel <= '0;
`ifdef VRAM_TEST_PATTERN_EN
      else if (ctl_q[3]) pixel <= {6{ctl_q[2:0]}};
`endif
      else if (ctl_q[CTL_W-2]) pixel <= vram_read_data[PIX_W-1:0];
      else pixel <= vram_read_data[WORD_W-1:PIX_W];
    end
  end

endmodule

// File: tb/tb_vram_frame_reader.sv
// Directed bench for vram_frame_reader: driver tasks push expected outputs into a
// scoreboard queue, a negedge monitor pops and compares when each result is due.
module tb_vram_frame_reader;
  import vram_pkg::*;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
  logic        frame_in = 1'b0, test_mode = 1'b0;
  logic [35:0] vram_read_data;
  logic [18:0] vram_addr;
  logic        vram_bank;
  logic [17:0] pixel;
  logic        pixel_valid, hsync_out, vsync_out, blank_out;
  rd_state_e   fsm_state;

  vram_frame_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hcount         (hcount),
    .vcount         (vcount),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .blank_in       (blank_in),
    .frame_in       (frame_in),
    .test_mode      (test_mode),
    .vram_read_data (vram_read_data),
    .vram_addr      (vram_addr),
    .vram_bank      (vram_bank),
    .pixel          (pixel),
    .pixel_valid    (pixel_valid),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .blank_out      (blank_out),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  // ZBT model: data for the address seen two cycles earlier
  function automatic logic [35:0] mem_word(input logic [18:0] a);
    if (a == {9'd1, 1'b1, 9'd2}) return {18'h2AAAA, 18'h15555};
    return {a[17:0] ^ 18'h3C3C3, a[18:1] ^ 18'h0B0B5};
  endfunction

  logic [18:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1 <= vram_addr;
    a2 <= a1;
  end
  assign vram_read_data = mem_word(a2);

  // scoreboard
  logic [21:0] exp_q[$];
  int          due_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at tick %0d: got %h expected %h", name, tick, act, exp);
    end
  endtask

  logic [21:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      while (due_q.size() > 0 && due_q[0] <= tick) begin
        mon_exp = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("pixel_out", 48'({hsync_out, vsync_out, blank_out, pixel_valid, pixel}), 48'(mon_exp));
      end
    end
  end

  // reference model state
  logic        m_run = 1'b0, m_bank = 1'b0, m_fs1 = 1'b0, m_fs2 = 1'b0;
  logic [18:0] m_addr = '0;
  logic        cur_fi = 1'b0, cur_tm = 1'b0;

  function automatic logic f_hs(input int h);
    return (h >= 656) && (h < 752);
  endfunction
  function automatic logic f_vs(input int v);
    return (v >= 490) && (v < 492);
  endfunction
  function automatic logic f_bl(input int h, input int v);
    return (h >= 720) || (v >= 480);
  endfunction

  // driver
  task automatic cyc(input int h, input int v);
    logic [10:0] xx, yy;
    logic        win, val;
    logic [18:0] a;
    logic [35:0] d;
    logic [17:0] p;
    hcount    = 11'(h);
    vcount    = 10'(v);
    hsync_in  = f_hs(h);
    vsync_in  = f_vs(v);
    blank_in  = f_bl(h, v);
    frame_in  = cur_fi;
    test_mode = cur_tm;
    xx  = 11'(h);
    yy  = 11'(v);
    win = (xx < 11'd720) && (yy < 11'd480);
    val = win && m_run;
    a   = {yy[9:0], xx[9:1]};
    d   = mem_word(a);
    p   = xx[0] ? d[17:0] : d[35:18];
`ifdef VRAM_TEST_PATTERN_EN
    if (cur_tm) p = {6{xx[9:7]}};
`endif
    if (!val) p = '0;
    exp_q.push_back({f_hs(h), f_vs(v), f_bl(h, v), val, p});
    due_q.push_back(tick + L);
    if (win) m_addr = a;
    if (h == 0 && v == 0) begin
      m_bank = ~m_fs2;
      m_run  = 1'b1;
    end
    m_fs2 = m_fs1;
    m_fs1 = cur_fi;
    @(posedge clk);
    #1;
    chk("vram_addr", 48'(vram_addr), 48'(m_addr));
    chk("vram_bank", 48'(vram_bank), 48'(m_bank));
    chk("fsm_state", 48'(fsm_state), 48'(m_run ? RUN : WAIT_FRAME));
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) cyc(h, v);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    m_run  = 1'b0;
    m_bank = 1'b0;
    m_fs1  = 1'b0;
    m_fs2  = 1'b0;
    m_addr = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_outputs",
          48'({vram_addr, vram_bank, pixel, pixel_valid, hsync_out, vsync_out, blank_out}), 48'd0);
      chk("reset_state", 48'(fsm_state), 48'(WAIT_FRAME));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    line(5, 10, 15);               // waiting for frame start: black
    line(3, 4, 5);
    cyc(0, 0);                     // frame start: RUN, bank <= ~0
    cyc(4, 3);                     // addr {1,1,2}, pixel 2AAAA
    cyc(5, 3);                     // pixel 15555
    line(3, 6, 12);
    line(479, 712, 725);           // right edge on last line
    line(480, 0, 4);               // below the image: address holds
    cur_fi = 1'b1;                 // writer toggles mid-frame
    line(100, 640, 770);           // 96-cycle hsync pulse, bank must hold
    cur_tm = 1'b1;
    cyc(300, 50);
    cyc(301, 50);
    cur_tm = 1'b0;
    cyc(300, 51);
    for (int v = 489; v <= 492; v++) line(v, 0, 3);
    cyc(0, 0);                     // frame start: bank <= ~1
    line(0, 1, 6);
    line(200, 100, 105);
    do_reset();                    // mid-frame reset: black until next frame
    line(200, 106, 112);
    cyc(0, 0);
    line(0, 1, 4);
    line(520, 0, L + 1);           // drain the pipeline
    repeat (L + 2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
